// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: commit-side exception types, ExcCode values,
// register addresses and Status/Cause bit positions.
package cp0_reg_pkg;

  localparam int EXCT_W = 4;

  typedef enum logic [EXCT_W-1:0] {
    EXCT_NONE  = 4'd0,
    EXCT_INTR  = 4'd1,
    EXCT_ADEL1 = 4'd2,
    EXCT_ADEL2 = 4'd3,
    EXCT_ADES  = 4'd4,
    EXCT_OV    = 4'd5,
    EXCT_SYSC  = 4'd6,
    EXCT_BP    = 4'd7,
    EXCT_RI    = 4'd8,
    EXCT_ERET  = 4'd9
  } exct_e;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0A;
  localparam logic [4:0] EXCCODE_OV   = 5'h0C;

  // {rd[4:0], sel[2:0]}
  localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] ADDR_ERROREPC = {5'd30, 3'd0};

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LSB = 8;
  localparam int STATUS_BEV    = 22;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_BD      = 31;

  function automatic logic [4:0] exc_code(input exct_e t);
    case (t)
      EXCT_ADEL1, EXCT_ADEL2: return EXCCODE_ADEL;
      EXCT_ADES:              return EXCCODE_ADES;
      EXCT_SYSC:              return EXCCODE_SYS;
      EXCT_BP:                return EXCCODE_BP;
      EXCT_RI:                return EXCCODE_RI;
      EXCT_OV:                return EXCCODE_OV;
      default:                return EXCCODE_INT;
    endcase
  endfunction

  function automatic logic is_addr_exc(input exct_e t);
    return t inside {EXCT_ADEL1, EXCT_ADEL2, EXCT_ADES};
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// MFC0/MTC0 access, exception-commit and status lines between the pipeline and CP0.
interface cp0_reg_if;
  logic [5:0]                     ext_int_i;
  logic                           we_i;
  logic [7:0]                     waddr_i;
  logic [31:0]                    wdata_i;
  logic [7:0]                     raddr_i;
  logic [31:0]                    rdata_o;
  logic                           exc_flag_i;
  logic [cp0_reg_pkg::EXCT_W-1:0] exc_type_i;
  logic [31:0]                    exc_pc_i;
  logic [31:0]                    exc_baddr_i;
  logic                           exc_bd_i;
  logic [31:0]                    epc_o;
  logic [31:0]                    errorepc_o;
  logic                           intr_o;
  logic [31:0]                    status_o;
  logic [31:0]                    cause_o;

  modport slave (
    input  ext_int_i, we_i, waddr_i, wdata_i, raddr_i,
           exc_flag_i, exc_type_i, exc_pc_i, exc_baddr_i, exc_bd_i,
    output rdata_o, epc_o, errorepc_o, intr_o, status_o, cause_o
  );

  modport master (
    output ext_int_i, we_i, waddr_i, wdata_i, raddr_i,
           exc_flag_i, exc_type_i, exc_pc_i, exc_baddr_i, exc_bd_i,
    input  rdata_o, epc_o, errorepc_o, intr_o, status_o, cause_o
  );
endinterface

// File: rtl/cp0_reg_timer.sv
// Count/Compare timer: Count advances every COUNT_DIV cycles, TI latches on
// Count == Compare until cleared.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic        clear_ti_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic        div_q, div_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        tick;

  // With COUNT_DIV == 1 the divider stays at 0 and every cycle ticks.
  assign tick = (div_q == 1'(COUNT_DIV - 1));

  always_comb begin
    div_d     = tick ? 1'b0 : div_q + 1'b1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
      div_d   = 1'b0;
    end
    if (compare_we_i) compare_d = wdata_i;
    if (clear_ti_i)                  ti_d = 1'b0;
    else if (count_q == compare_q)   ti_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q     <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: exception commit updates, MFC0/MTC0 access, interrupt
// qualification and the Count/Compare timer.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter int COUNT_DIV = 2,
  parameter int TIMER_IP  = 7
) (
  input logic      clk,
  input logic      resetn,
  cp0_reg_if.slave bus
);

  exct_e       exc_type;
  logic        exc_commit, eret_commit, wr_en;
  logic        count_we, compare_we;
  logic [31:0] count, compare;
  logic        ti;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d, errorepc_q, errorepc_d, badvaddr_q, badvaddr_d;

  logic [7:0]  ip;
  logic [31:0] status, cause;

  assign exc_type    = exct_e'(bus.exc_type_i);
  assign eret_commit = bus.exc_flag_i && (exc_type == EXCT_ERET);
  assign exc_commit  = bus.exc_flag_i && (exc_type != EXCT_ERET);
  // A committing exception or ERET swallows any MTC0 in the same cycle.
  assign wr_en       = bus.we_i && !bus.exc_flag_i;
  assign count_we    = wr_en && (bus.waddr_i == ADDR_COUNT);
  assign compare_we  = wr_en && (bus.waddr_i == ADDR_COMPARE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .count_we_i   (count_we),
    .compare_we_i (compare_we),
    .clear_ti_i   (compare_we),
    .wdata_i      (bus.wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = bus.ext_int_i;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    errorepc_d = errorepc_q;
    badvaddr_d = badvaddr_q;
    if (exc_commit) begin
      exl_d     = 1'b1;
      exccode_d = exc_code(exc_type);
      // Nested exceptions keep the original return point.
      if (!exl_q) begin
        epc_d = bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
        bd_d  = bus.exc_bd_i;
      end
      if (is_addr_exc(exc_type)) badvaddr_d = bus.exc_baddr_i;
    end else if (eret_commit) begin
      exl_d = 1'b0;
    end else if (wr_en) begin
      case (bus.waddr_i)
        ADDR_STATUS: begin
          im_d  = bus.wdata_i[STATUS_IM_LSB +: 8];
          exl_d = bus.wdata_i[STATUS_EXL];
          ie_d  = bus.wdata_i[STATUS_IE];
        end
        ADDR_CAUSE:    ip_sw_d    = bus.wdata_i[1:0];
        ADDR_EPC:      epc_d      = bus.wdata_i;
        ADDR_ERROREPC: errorepc_d = bus.wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      epc_q      <= '0;
      errorepc_q <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      errorepc_q <= errorepc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign ip = {ip_hw_q, ip_sw_q} | (8'(ti) << TIMER_IP);

  always_comb begin
    status                         = '0;
    status[STATUS_BEV]             = 1'b1;
    status[STATUS_IM_LSB +: 8]     = im_q;
    status[STATUS_EXL]             = exl_q;
    status[STATUS_IE]              = ie_q;
    cause                          = '0;
    cause[CAUSE_BD]                = bd_q;
    cause[CAUSE_TI]                = ti;
    cause[CAUSE_IP_LSB +: 8]       = ip;
    cause[CAUSE_EXC_LSB +: 5]      = exccode_q;
  end

  always_comb begin
    case (bus.raddr_i)
      ADDR_BADVADDR: bus.rdata_o = badvaddr_q;
      ADDR_COUNT:    bus.rdata_o = count;
      ADDR_COMPARE:  bus.rdata_o = compare;
      ADDR_STATUS:   bus.rdata_o = status;
      ADDR_CAUSE:    bus.rdata_o = cause;
      ADDR_EPC:      bus.rdata_o = epc_q;
      ADDR_ERROREPC: bus.rdata_o = errorepc_q;
      default:       bus.rdata_o = '0;
    endcase
  end

  assign bus.epc_o      = (bus.we_i && (bus.waddr_i == ADDR_EPC)) ? bus.wdata_i : epc_q;
  assign bus.errorepc_o = errorepc_q;
  assign bus.intr_o     = (|(ip & im_q)) & ie_q & ~exl_q;
  assign bus.status_o   = status;
  assign bus.cause_o    = cause;

endmodule
